// File: rtl/mix_columns_engine.sv
// mix_columns_engine: iterative AES (Inv)MixColumns engine.
//
// Accepts one 128-bit AES state, transforms COLS_PER_CYCLE columns per cycle in a
// working register, then presents the result until the consumer takes it.
//
// Parameters:
//   COLS_PER_CYCLE  columns transformed per cycle (1, 2 or 4)
//   STAGES          derived cycles per block, 4 / COLS_PER_CYCLE (not overridable)
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   in_data / in_inv offered
//   in_ready   engine idle, can accept a block
//   in_data    AES state; column i = bits [32i+31:32i], row-0 byte at column MSB
//   in_inv     1 = InvMixColumns, 0 = MixColumns
//   out_valid  out_data holds a completed result
//   out_ready  consumer accepts out_data
//   out_data   transformed state, same layout as in_data
//   busy       high whenever the engine is not idle
//
// Build option:
//   MIXCOL_FWD_EN  when defined, the forward datapath is built and in_inv selects the
//                  mode; otherwise every block uses InvMixColumns and in_inv is ignored.

module mix_columns_engine #(
  parameter  int COLS_PER_CYCLE = 1,
  localparam int STAGES         = 4 / COLS_PER_CYCLE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  // One spare bit so the counter can reach STAGES without wrapping.
  localparam int CNT_W = $clog2(STAGES) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // GF(2^8) helpers, reduction polynomial 0x11B.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] mb(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] md(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] me(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3),
            m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3),
            md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3),
            mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3)};
  endfunction

`ifdef MIXCOL_FWD_EN
  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     work_q, work_d;

`ifdef MIXCOL_FWD_EN
  logic inv_q, inv_d;
`else
  logic unused_inv;
  assign unused_inv = in_inv;
`endif

  logic [31:0] col_in  [COLS_PER_CYCLE];
  logic [31:0] col_out [COLS_PER_CYCLE];

  // Select the columns belonging to the current stage; cnt_q is the stage index.
  always_comb begin
    for (int c = 0; c < COLS_PER_CYCLE; c++) begin
      col_in[c] = '0;
      for (int s = 0; s < STAGES; s++) begin
        if (cnt_q == CNT_W'(s)) begin
          col_in[c] = work_q[32*(s*COLS_PER_CYCLE+c) +: 32];
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < COLS_PER_CYCLE; c++) begin
`ifdef MIXCOL_FWD_EN
      col_out[c] = inv_q ? inv_col(col_in[c]) : fwd_col(col_in[c]);
`else
      col_out[c] = inv_col(col_in[c]);
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
`ifdef MIXCOL_FWD_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = '0;
          state_d = BUSY;
`ifdef MIXCOL_FWD_EN
          inv_d   = in_inv;
`endif
        end
      end
      BUSY: begin
        for (int s = 0; s < STAGES; s++) begin
          if (cnt_q == CNT_W'(s)) begin
            for (int c = 0; c < COLS_PER_CYCLE; c++) begin
              work_d[32*(s*COLS_PER_CYCLE+c) +: 32] = col_out[c];
            end
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STAGES - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
`ifdef MIXCOL_FWD_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
`ifdef MIXCOL_FWD_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = work_q;

endmodule

// File: doc/mix_columns_engine.md
MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1: columns processed per cycle; legal values 1, 2, 4.
REQ-002 SHALL have parameter STAGES, default 4/COLS_PER_CYCLE: derived cycles per block; not overridable.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: in_data and in_inv offered.
REQ-006 SHALL have port in_ready, output, 1: engine can accept a block.
REQ-007 SHALL have port in_data, input, 128: AES state; column i = bits [32i+31:32i], row-0 byte at the column MSB.
REQ-008 SHALL have port in_inv, input, 1: 1 = InvMixColumns, 0 = MixColumns.
REQ-009 SHALL have port out_valid, output, 1: out_data holds a completed result.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts out_data.
REQ-011 SHALL have port out_data, output, 128: transformed state, same column layout as in_data.
REQ-012 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in BUSY and DONE, in_ready SHALL be 0.
REQ-015 An accept (in_valid & in_ready) SHALL latch in_data and in_inv, clear the column counter and move to BUSY.
REQ-016 In BUSY, each cycle SHALL transform COLS_PER_CYCLE columns, ascending from column 0, writing results into the working register in place.
REQ-017 Forward mode SHALL use matrix rows {02 03 01 01} rotated per output row; inverse mode SHALL use rows {0e 0b 0d 09} rotated per output row; all arithmetic SHALL be in GF(2^8) modulo 0x11B.
REQ-018 After STAGES BUSY cycles, the FSM SHALL enter DONE with out_valid=1; an accept at cycle T SHALL give out_valid at T+STAGES.
REQ-019 In DONE, out_data SHALL be held stable until out_valid & out_ready, after which the FSM SHALL return to IDLE.
REQ-020 out_ready SHALL be ignored outside DONE, and in_valid and in_inv SHALL be ignored outside IDLE; a mode change mid-block SHALL NOT affect the block.
REQ-021 Sustained throughput SHALL be one block per STAGES+2 cycles when out_ready is held at 1.
REQ-022 out_data SHALL reflect the working register; the value is meaningful only while out_valid=1.
REQ-023 The column counter SHALL be ceil(log2(STAGES))+1 bits wide and SHALL NOT wrap within a block.

Reset
REQ-024 When rst_n=0 at a clock edge, the FSM SHALL enter IDLE, and out_valid, busy, the counter, the working register, out_data and the latched mode SHALL all clear to 0.
REQ-025 Reset in BUSY or DONE SHALL abort the block without emitting it; the first accept after reset release SHALL behave normally.

Configuration
REQ-026 With macro MIXCOL_FWD_EN defined, both modes SHALL be compiled in and selected by in_inv.
REQ-027 Without MIXCOL_FWD_EN, the forward datapath SHALL be absent, in_inv SHALL be ignored and every block SHALL use InvMixColumns; timing and handshake SHALL be unchanged.

Verification
REQ-028 MIXCOL_FWD_EN defined, in_inv=0, column 0 = 0xdb135345, other columns 0xf20a225c -> column 0 = 0x8e4da1bc and others 0x9fdc589d, with out_valid exactly STAGES cycles after accept.
REQ-029 in_inv=1, all columns = 0x8e4da1bc -> all columns 0xdb135345; repeat with 0x9fdc589d -> 0xf20a225c.
REQ-030 Columns 0x01010101 and 0xc6c6c6c6 in either mode -> output equals input; run for COLS_PER_CYCLE = 1, 2 and 4, checking latencies of 4, 2 and 1.
REQ-031 Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 -> out_data stable, in_ready=0, no second accept; out_ready=1 -> IDLE on the next cycle.
REQ-032 Toggle in_inv during BUSY -> result matches the mode latched at accept.
REQ-033 Assert rst_n=0 for one cycle in the second BUSY cycle -> out_valid never asserts for that block, all outputs read 0 and in_ready=1 on the next cycle.
